// File: rtl/lte_srcx1_sched.sv
// Frame-synchronous test-entry scheduler for the single-carrier LTE source interface.
// Steps a processor-written table, holding each entry on the outputs for rpt+1 frame headers.
module lte_srcx1_sched #(
    parameter int NUM_ENT   = 8,
    parameter int IDX_W     = 3,
    parameter int FRAME_LEN = 4915200,
    parameter int HD_TOL    = 64
) (
    input  logic             clk,
    input  logic             asy_rst,
    input  logic             i_enable,
    input  logic             i_framn_hd,
    input  logic [IDX_W:0]   i_num_ent,
    input  logic             i_cfg_wr,
    input  logic [IDX_W-1:0] i_cfg_addr,
    input  logic [55:0]      i_cfg_data,
    input  logic             i_err_clr,
    output logic [2:0]       o_test_vld,
    output logic             o_test_sel,
    output logic [31:0]      o_data_start,
    output logic [31:0]      o_data_end,
    output logic [IDX_W-1:0] o_entry_idx,
    output logic             o_busy,
    output logic [15:0]      o_frame_cnt,
    output logic             o_hd_lost,
    output logic             o_cfg_err
);
    localparam int HD_LIM = FRAME_LEN + HD_TOL;
    localparam int CNT_W  = $clog2(HD_LIM + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HD = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t           state_q;
    logic [55:0]      tbl_q [NUM_ENT];
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       rpt_cnt_q;
    logic [CNT_W-1:0] cyc_q;
    logic [2:0]       vld_q;
    logic             sel_q;
    logic [23:0]      start_q;
    logic [23:0]      end_q;
    logic             busy_q;
    logic [15:0]      frame_cnt_q;
    logic             hd_lost_q;
    logic             cfg_err_q;
    logic             cfg_err_d;

    logic             num_bad_s;
    logic [IDX_W:0]   last_idx_s;
    logic             hd_act_s;
    logic             load_s;
    logic [IDX_W-1:0] load_idx_s;
    logic [55:0]      load_data_s;
    logic             win_err_s;
    logic             timeout_s;

    // Effective entry count, next load target (with same-cycle write bypass) and error sources.
    always_comb begin
        num_bad_s  = (i_num_ent == (IDX_W+1)'(0)) || (i_num_ent > (IDX_W+1)'(NUM_ENT));
        last_idx_s = num_bad_s ? (IDX_W+1)'(0) : (i_num_ent - (IDX_W+1)'(1));
        hd_act_s   = i_enable && i_framn_hd && ((state_q == ST_WAIT_HD) || (state_q == ST_RUN));
        if (state_q == ST_WAIT_HD) begin
            load_s     = hd_act_s;
            load_idx_s = IDX_W'(0);
        end else begin
            load_s = hd_act_s && (rpt_cnt_q == 4'd0);
            // >= also covers the case where the active count shrank below the current index
            if ({1'b0, idx_q} >= last_idx_s) begin
                load_idx_s = IDX_W'(0);
            end else begin
                load_idx_s = idx_q + IDX_W'(1);
            end
        end
        if (i_cfg_wr && (i_cfg_addr == load_idx_s)) begin
            load_data_s = i_cfg_data;
        end else begin
            load_data_s = tbl_q[load_idx_s];
        end
        win_err_s = load_s && (load_data_s[23:0] > load_data_s[47:24]);
        timeout_s = (state_q == ST_RUN) && i_enable && !i_framn_hd &&
                    (cyc_q == CNT_W'(HD_LIM - 1));
        if (win_err_s || (hd_act_s && num_bad_s)) begin
            cfg_err_d = 1'b1;
        end else if (i_err_clr) begin
            cfg_err_d = 1'b0;
        end else begin
            cfg_err_d = cfg_err_q;
        end
    end

    // Configuration table, writable in any state.
    always_ff @(posedge clk) begin
        if (asy_rst) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                tbl_q[i] <= 56'd0;
            end
        end else if (i_cfg_wr) begin
            tbl_q[i_cfg_addr] <= i_cfg_data;
        end
    end

    // Scheduler FSM with shadow output registers.
    always_ff @(posedge clk) begin
        if (asy_rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= IDX_W'(0);
            rpt_cnt_q   <= 4'd0;
            cyc_q       <= CNT_W'(0);
            vld_q       <= 3'd0;
            sel_q       <= 1'b0;
            start_q     <= 24'd0;
            end_q       <= 24'd0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
            hd_lost_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            hd_lost_q <= 1'b0;
            cfg_err_q <= cfg_err_d;
            if ((state_q != ST_IDLE) && !i_enable) begin
                state_q     <= ST_IDLE;
                idx_q       <= IDX_W'(0);
                rpt_cnt_q   <= 4'd0;
                cyc_q       <= CNT_W'(0);
                vld_q       <= 3'd0;
                sel_q       <= 1'b0;
                start_q     <= 24'd0;
                end_q       <= 24'd0;
                busy_q      <= 1'b0;
                frame_cnt_q <= 16'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_enable) begin
                            state_q <= ST_WAIT_HD;
                        end
                    end
                    ST_WAIT_HD: begin
                        if (i_framn_hd) begin
                            state_q     <= ST_RUN;
                            frame_cnt_q <= 16'd0;
                            busy_q      <= 1'b1;
                            cyc_q       <= CNT_W'(0);
                        end
                    end
                    ST_RUN: begin
                        if (i_framn_hd) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            cyc_q       <= CNT_W'(0);
                            if (!load_s) begin
                                rpt_cnt_q <= rpt_cnt_q - 4'd1;
                            end
                        end else if (timeout_s) begin
                            hd_lost_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= ST_WAIT_HD;
                        end else begin
                            cyc_q <= cyc_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
                if (load_s) begin
                    idx_q     <= load_idx_s;
                    rpt_cnt_q <= load_data_s[55:52];
                    sel_q     <= load_data_s[51];
                    vld_q     <= load_data_s[50:48];
                    end_q     <= load_data_s[47:24];
                    start_q   <= load_data_s[23:0];
                end
            end
        end
    end

    assign o_test_vld   = vld_q;
    assign o_test_sel   = sel_q;
    assign o_data_start = {8'd0, start_q};
    assign o_data_end   = {8'd0, end_q};
    assign o_entry_idx  = idx_q;
    assign o_busy       = busy_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_hd_lost    = hd_lost_q;
    assign o_cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_lte_srcx1_sched.sv
// Randomised self-checking bench for lte_srcx1_sched against a frame-level scheduling model.
// A short frame length keeps header-timeout scenarios within a few hundred cycles.
module tb_lte_srcx1_sched;
    localparam int NUM_ENT   = 8;
    localparam int IDX_W     = 3;
    localparam int FRAME_LEN = 40;
    localparam int HD_TOL    = 8;
    localparam int LIM       = FRAME_LEN + HD_TOL;

    logic        clk = 1'b0;
    logic        asy_rst = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_framn_hd = 1'b0;
    logic [3:0]  i_num_ent = 4'd1;
    logic        i_cfg_wr = 1'b0;
    logic [2:0]  i_cfg_addr = 3'd0;
    logic [55:0] i_cfg_data = 56'd0;
    logic        i_err_clr = 1'b0;
    logic [2:0]  o_test_vld;
    logic        o_test_sel;
    logic [31:0] o_data_start;
    logic [31:0] o_data_end;
    logic [2:0]  o_entry_idx;
    logic        o_busy;
    logic [15:0] o_frame_cnt;
    logic        o_hd_lost;
    logic        o_cfg_err;
    logic [89:0] dut_vec;

    int checks = 0;
    int failures = 0;

    lte_srcx1_sched #(.NUM_ENT(NUM_ENT), .IDX_W(IDX_W), .FRAME_LEN(FRAME_LEN), .HD_TOL(HD_TOL)) dut (
        .clk(clk), .asy_rst(asy_rst), .i_enable(i_enable), .i_framn_hd(i_framn_hd),
        .i_num_ent(i_num_ent), .i_cfg_wr(i_cfg_wr), .i_cfg_addr(i_cfg_addr),
        .i_cfg_data(i_cfg_data), .i_err_clr(i_err_clr), .o_test_vld(o_test_vld),
        .o_test_sel(o_test_sel), .o_data_start(o_data_start), .o_data_end(o_data_end),
        .o_entry_idx(o_entry_idx), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt),
        .o_hd_lost(o_hd_lost), .o_cfg_err(o_cfg_err)
    );

    always #5 clk = ~clk;

    assign dut_vec = {o_test_vld, o_test_sel, o_data_start, o_data_end, o_entry_idx,
                      o_busy, o_frame_cnt, o_hd_lost, o_cfg_err};

    // Reference model: mode 0 idle, 1 waiting for header, 2 running.
    logic [55:0] m_tbl [NUM_ENT];
    int          m_mode = 0;
    int          m_idx = 0;
    int          m_age = 0;
    int          m_frame = 0;
    int          m_since = 0;
    logic [55:0] m_ent = 56'd0;
    bit          m_busy = 1'b0;
    bit          m_lost = 1'b0;
    bit          m_err = 1'b0;

    task automatic m_edge();
        bit set = 1'b0;
        bit loaded = 1'b0;
        bit bad;
        int eff;
        m_lost = 1'b0;
        if (asy_rst) begin
            foreach (m_tbl[i]) m_tbl[i] = 56'd0;
            m_mode = 0; m_idx = 0; m_age = 0; m_frame = 0; m_since = 0;
            m_ent = 56'd0; m_busy = 1'b0; m_err = 1'b0;
            return;
        end
        if (i_cfg_wr) m_tbl[i_cfg_addr] = i_cfg_data;
        bad = (i_num_ent == 4'd0) || (int'(i_num_ent) > NUM_ENT);
        eff = bad ? 1 : int'(i_num_ent);
        if (m_mode != 0 && !i_enable) begin
            m_mode = 0; m_idx = 0; m_frame = 0; m_ent = 56'd0; m_busy = 1'b0;
        end else if (m_mode == 0) begin
            if (i_enable) m_mode = 1;
        end else if (i_framn_hd) begin
            set = bad;
            m_since = 0;
            if (m_mode == 1) begin
                m_mode = 2; m_busy = 1'b1; m_frame = 0; m_idx = 0; m_age = 0;
                m_ent = m_tbl[0]; loaded = 1'b1;
            end else begin
                m_frame = (m_frame + 1) % 65536;
                m_age++;
                if (m_age > int'(m_ent[55:52])) begin
                    m_idx = (m_idx + 1 >= eff) ? 0 : m_idx + 1;
                    m_ent = m_tbl[m_idx]; m_age = 0; loaded = 1'b1;
                end
            end
        end else if (m_mode == 2) begin
            m_since++;
            if (m_since == LIM) begin
                m_lost = 1'b1; m_busy = 1'b0; m_mode = 1;
            end
        end
        if (loaded && (m_ent[23:0] > m_ent[47:24])) set = 1'b1;
        if (set) m_err = 1'b1;
        else if (i_err_clr) m_err = 1'b0;
    endtask

    function automatic logic [89:0] m_vec();
        return {m_ent[50:48], m_ent[51], 8'd0, m_ent[23:0], 8'd0, m_ent[47:24], 3'(m_idx),
                m_busy, 16'(m_frame), m_lost, m_err};
    endfunction

    function automatic logic [55:0] rnd_ent(input logic [3:0] rpt);
        logic [23:0] s;
        logic [23:0] e;
        s = 24'($urandom_range(0, 5000));
        e = s + 24'($urandom_range(0, 5000));
        return {rpt, 1'($urandom), 3'($urandom), e, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [55:0] d);
        i_cfg_wr = 1'b1; i_cfg_addr = a; i_cfg_data = d;
        tick();
        i_cfg_wr = 1'b0;
    endtask

    task automatic hd();
        i_framn_hd = 1'b1;
        tick();
        i_framn_hd = 1'b0;
    endtask

    task automatic restart();
        i_enable = 1'b0;
        tick();
        i_enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        asy_rst = 1'b1;
        tick(); tick();
        checks++;
        if (dut_vec !== 90'd0) begin
            failures++; $display("FAIL reset_outputs: got %h exp 0", dut_vec);
        end
        asy_rst = 1'b0;
        tick();
        checks++;
        if (dut_vec !== m_vec()) begin
            failures++; $display("FAIL reset_model: got %h exp %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_basic();
        wr(3'd0, {4'd0, 1'b1, 3'b001, 24'd1000, 24'd200});
        i_num_ent = 4'd1;
        i_enable = 1'b1;
        repeat (5) tick();
        checks++;
        if (o_busy !== 1'b0 || o_test_vld !== 3'd0) begin
            failures++; $display("FAIL basic_prehdr: busy %b vld %0d exp 0 0", o_busy, o_test_vld);
        end
        hd();
        checks++;
        if ({o_test_vld, o_test_sel, o_data_start, o_data_end, o_busy, o_entry_idx} !==
            {3'd1, 1'b1, 32'd200, 32'd1000, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL basic_load: vld %0d sel %b st %0d end %0d busy %b idx %0d exp 1 1 200 1000 1 0",
                     o_test_vld, o_test_sel, o_data_start, o_data_end, o_busy, o_entry_idx);
        end
        checks++;
        if (dut_vec !== m_vec()) begin
            failures++; $display("FAIL basic_model: got %h exp %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_sequence();
        int exp_idx[8] = '{0, 0, 1, 2, 2, 2, 0, 0};
        wr(3'd0, rnd_ent(4'd1));
        wr(3'd1, rnd_ent(4'd0));
        wr(3'd2, rnd_ent(4'd2));
        i_num_ent = 4'd3;
        restart();
        for (int h = 0; h < 8; h++) begin
            repeat ($urandom_range(3, 30)) tick();
            hd();
            checks++;
            if (o_entry_idx !== 3'(exp_idx[h])) begin
                failures++; $display("FAIL seq_idx[%0d]: got %0d exp %0d", h, o_entry_idx, exp_idx[h]);
            end
            checks++;
            if (dut_vec !== m_vec()) begin
                failures++; $display("FAIL seq_model[%0d]: got %h exp %h", h, dut_vec, m_vec());
            end
        end
        checks++;
        if (o_frame_cnt !== 16'd7) begin
            failures++; $display("FAIL seq_frame_cnt: got %0d exp 7", o_frame_cnt);
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        for (int k = 1; k <= LIM + 4; k++) begin
            tick();
            if (o_hd_lost === 1'b1) pulses++;
            checks++;
            if (o_hd_lost !== (k == LIM)) begin
                failures++; $display("FAIL timeout_pulse[%0d]: got %b exp %b", k, o_hd_lost, (k == LIM));
            end
            checks++;
            if (dut_vec !== m_vec()) begin
                failures++; $display("FAIL timeout_model[%0d]: got %h exp %h", k, dut_vec, m_vec());
            end
        end
        checks++;
        if (pulses != 1 || o_busy !== 1'b0) begin
            failures++; $display("FAIL timeout_summary: pulses %0d busy %b exp 1 0", pulses, o_busy);
        end
        hd();
        checks++;
        if (o_entry_idx !== 3'd0 || o_frame_cnt !== 16'd0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_reload: idx %0d frame %0d busy %b exp 0 0 1", o_entry_idx, o_frame_cnt, o_busy);
        end
    endtask

    task automatic test_write_active();
        wr(3'd0, {4'd0, 1'b0, 3'd2, 24'd900, 24'd100});
        wr(3'd1, {4'd0, 1'b1, 3'd5, 24'd800, 24'd300});
        i_num_ent = 4'd2;
        restart();
        hd();
        repeat (3) tick();
        wr(3'd0, {4'd0, 1'b1, 3'd7, 24'd700, 24'd50});
        repeat (3) tick();
        checks++;
        if (o_data_start !== 32'd100 || o_test_vld !== 3'd2) begin
            failures++; $display("FAIL wr_active_hold: st %0d vld %0d exp 100 2", o_data_start, o_test_vld);
        end
        i_cfg_wr = 1'b1; i_cfg_addr = 3'd1; i_cfg_data = {4'd0, 1'b0, 3'd4, 24'd600, 24'd60};
        hd();
        i_cfg_wr = 1'b0;
        checks++;
        if (o_data_start !== 32'd60 || o_data_end !== 32'd600 || o_entry_idx !== 3'd1) begin
            failures++;
            $display("FAIL wr_bypass: st %0d end %0d idx %0d exp 60 600 1", o_data_start, o_data_end, o_entry_idx);
        end
        repeat (4) tick();
        hd();
        checks++;
        if (o_data_start !== 32'd50 || o_test_vld !== 3'd7 || o_entry_idx !== 3'd0) begin
            failures++;
            $display("FAIL wr_reload: st %0d vld %0d idx %0d exp 50 7 0", o_data_start, o_test_vld, o_entry_idx);
        end
        checks++;
        if (dut_vec !== m_vec()) begin
            failures++; $display("FAIL wr_model: got %h exp %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_cfg_err();
        i_err_clr = 1'b1; tick(); i_err_clr = 1'b0;
        i_num_ent = 4'd0;
        restart();
        for (int h = 0; h < 4; h++) begin
            repeat (5) tick();
            hd();
            checks++;
            if (o_entry_idx !== 3'd0 || o_cfg_err !== 1'b1) begin
                failures++; $display("FAIL num0[%0d]: idx %0d err %b exp 0 1", h, o_entry_idx, o_cfg_err);
            end
        end
        i_err_clr = 1'b1; tick(); i_err_clr = 1'b0;
        checks++;
        if (o_cfg_err !== 1'b0) begin
            failures++; $display("FAIL err_clear: got %b exp 0", o_cfg_err);
        end
        wr(3'd1, {4'd0, 1'b0, 3'd1, 24'd100, 24'd500});
        i_num_ent = 4'd2;
        hd();
        checks++;
        if (o_cfg_err !== 1'b1 || o_data_start !== 32'd500 || o_data_end !== 32'd100) begin
            failures++;
            $display("FAIL bad_window: err %b st %0d end %0d exp 1 500 100", o_cfg_err, o_data_start, o_data_end);
        end
        hd();
        i_err_clr = 1'b1;
        hd();
        i_err_clr = 1'b0;
        checks++;
        if (o_cfg_err !== 1'b1) begin
            failures++; $display("FAIL set_wins: got %b exp 1", o_cfg_err);
        end
        i_err_clr = 1'b1; tick(); i_err_clr = 1'b0;
        checks++;
        if (o_cfg_err !== 1'b0 || dut_vec !== m_vec()) begin
            failures++; $display("FAIL err_clear2: got %h exp %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 4; i++) wr(3'(i), rnd_ent(4'd0));
        i_num_ent = 4'd4;
        restart();
        repeat (4) begin
            repeat (3) tick();
            hd();
        end
        checks++;
        if (o_entry_idx !== 3'd3) begin
            failures++; $display("FAIL clamp_pre: got %0d exp 3", o_entry_idx);
        end
        i_num_ent = 4'd2;
        hd();
        checks++;
        if (o_entry_idx !== 3'd0) begin
            failures++; $display("FAIL clamp_wrap: got %0d exp 0", o_entry_idx);
        end
        i_num_ent = 4'd9;
        hd();
        checks++;
        if (o_entry_idx !== 3'd0 || o_cfg_err !== 1'b1) begin
            failures++; $display("FAIL num9: idx %0d err %b exp 0 1", o_entry_idx, o_cfg_err);
        end
    endtask

    task automatic test_disable();
        i_num_ent = 4'd4;
        restart();
        hd(); hd();
        i_enable = 1'b0;
        hd();
        checks++;
        if (dut_vec[89:1] !== 89'd0) begin
            failures++; $display("FAIL disable_hdr: got %h exp 0", dut_vec[89:1]);
        end
        repeat (2) tick();
        checks++;
        if (dut_vec !== m_vec()) begin
            failures++; $display("FAIL disable_model: got %h exp %h", dut_vec, m_vec());
        end
        i_enable = 1'b1;
        tick();
        hd();
        checks++;
        if (o_entry_idx !== 3'd0 || o_busy !== 1'b1) begin
            failures++; $display("FAIL reenable: idx %0d busy %b exp 0 1", o_entry_idx, o_busy);
        end
    endtask

    task automatic test_midrun_reset();
        hd();
        asy_rst = 1'b1; tick(); asy_rst = 1'b0;
        checks++;
        if (dut_vec !== 90'd0) begin
            failures++; $display("FAIL midrun_reset: got %h exp 0", dut_vec);
        end
        i_num_ent = 4'd3;
        tick();
        for (int h = 0; h < 3; h++) begin
            hd();
            checks++;
            if ({o_test_vld, o_test_sel, o_data_start, o_data_end, o_cfg_err} !== 69'd0 ||
                o_entry_idx !== 3'(h) || o_busy !== 1'b1) begin
                failures++;
                $display("FAIL cleared_tbl[%0d]: vld %0d st %0d end %0d idx %0d busy %b exp 0 0 0 %0d 1",
                         h, o_test_vld, o_data_start, o_data_end, o_entry_idx, o_busy, h);
            end
        end
    endtask

    task automatic test_random();
        i_num_ent = 4'd4;
        for (int n = 0; n < 60; n++) begin
            int gap = $urandom_range(1, LIM + 6);
            for (int c = 0; c < gap; c++) begin
                i_cfg_wr   = ($urandom_range(0, 5) == 0);
                i_cfg_addr = 3'($urandom);
                i_cfg_data = {24'($urandom), $urandom()};
                i_err_clr  = ($urandom_range(0, 15) == 0);
                i_enable   = ($urandom_range(0, 99) != 0);
                i_framn_hd = (c == gap - 1);
                tick();
                checks++;
                if (dut_vec !== m_vec()) begin
                    failures++; $display("FAIL random[%0d.%0d]: got %h exp %h", n, c, dut_vec, m_vec());
                end
            end
            if ($urandom_range(0, 3) == 0) i_num_ent = 4'($urandom_range(0, 15));
        end
        i_cfg_wr = 1'b0; i_err_clr = 1'b0; i_framn_hd = 1'b0; i_enable = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_sequence();
        test_timeout();
        test_write_active();
        test_cfg_err();
        test_clamp();
        test_disable();
        test_midrun_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
